// File: rtl/req_throttle.sv
// Request throttle: buffers c0 reads and c1 writes, issues under alm_full and read-credit limits, RUN/DRAIN/DONE drain FSM.
// Latency: an accept cycle is followed one cycle later by the registered out_valid, 1 request/cycle sustained.
// Backpressure: ready drops on FIFO full or drain gating; REQ_THROTTLE_STATS_EN enables stall counters.
`timescale 1ns/1ps

module req_throttle_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_head_dat,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PTR_ONE;
      if (i_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_push_dat;
  end

  assign o_head_dat = r_mem[r_rptr[AW-1:0]];
  assign o_empty    = (r_wptr == r_rptr);
  assign o_full     = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
endmodule

module req_throttle #(
  parameter int C0_HDR_W     = 74,
  parameter int C1_HDR_W     = 80,
  parameter int DATA_W       = 512,
  parameter int FIFO_DEPTH   = 4,
  parameter int MAX_RD_LINES = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_c0_valid,
  input  logic [C0_HDR_W-1:0] in_c0_hdr,
  input  logic [1:0]          in_c0_len,
  output logic                in_c0_ready,
  input  logic                in_c1_valid,
  input  logic [C1_HDR_W-1:0] in_c1_hdr,
  input  logic [DATA_W-1:0]   in_c1_data,
  input  logic                in_c1_sop,
  output logic                in_c1_ready,
  output logic                out_c0_valid,
  output logic [C0_HDR_W-1:0] out_c0_hdr,
  output logic                out_c1_valid,
  output logic [C1_HDR_W-1:0] out_c1_hdr,
  output logic [DATA_W-1:0]   out_c1_data,
  input  logic                c0_alm_full,
  input  logic                c1_alm_full,
  input  logic                rd_rsp_valid,
  input  logic                wr_rsp_valid,
  input  logic [1:0]          wr_rsp_lines,
  input  logic                drain_req,
  output logic                drain_done,
  output logic [7:0]          rd_outstanding,
  output logic [7:0]          wr_outstanding,
  output logic                err_underflow,
  output logic [31:0]         stall_af_cnt,
  output logic [31:0]         stall_cr_cnt
);
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam int C0_W = C0_HDR_W + 2;
  localparam int C1_W = C1_HDR_W + DATA_W + 1;

  logic [1:0]          r_state;
  logic                r_c1_started;
  logic                r_out_c0_vld;
  logic [C0_HDR_W-1:0] r_out_c0_hdr;
  logic                r_out_c1_vld;
  logic [C1_HDR_W-1:0] r_out_c1_hdr;
  logic [DATA_W-1:0]   r_out_c1_data;
  logic [7:0]          r_rd_out;
  logic [7:0]          r_wr_out;
  logic                r_err;

  logic            w_c0_push, w_c0_full, w_c0_empty, w_c0_issue, w_c0_credit_ok;
  logic            w_c1_push, w_c1_full, w_c1_empty, w_c1_issue, w_c1_sop_eff;
  logic            w_c0_en, w_c1_en, w_idle, w_rd_uf, w_wr_uf;
  logic [C0_W-1:0] w_c0_head;
  logic [C1_W-1:0] w_c1_head;
  logic [9:0]      w_c0_lines, w_rd_need, w_rd_sum, w_wr_sum, w_wr_sub, w_rd_next, w_wr_next;

  // A c1 beat arriving before any beat since reset starts a packet, whatever its sop says.
  assign w_c1_sop_eff = in_c1_sop | ~r_c1_started;
  assign w_c0_en      = (r_state == S_RUN);
  assign w_c1_en      = (r_state == S_RUN) || ((r_state == S_DRAIN) && r_c1_started && !in_c1_sop);
  assign in_c0_ready  = !w_c0_full && w_c0_en;
  assign in_c1_ready  = !w_c1_full && w_c1_en;
  assign w_c0_push    = in_c0_valid && in_c0_ready;
  assign w_c1_push    = in_c1_valid && in_c1_ready;

  req_throttle_fifo #(.W(C0_W), .DEPTH(FIFO_DEPTH)) u_c0_fifo (
    .clk(clk), .reset_n(reset_n),
    .i_push(w_c0_push), .i_push_dat({in_c0_hdr, in_c0_len}),
    .i_pop(w_c0_issue), .o_head_dat(w_c0_head),
    .o_full(w_c0_full), .o_empty(w_c0_empty)
  );

  req_throttle_fifo #(.W(C1_W), .DEPTH(FIFO_DEPTH)) u_c1_fifo (
    .clk(clk), .reset_n(reset_n),
    .i_push(w_c1_push), .i_push_dat({in_c1_hdr, in_c1_data, w_c1_sop_eff}),
    .i_pop(w_c1_issue), .o_head_dat(w_c1_head),
    .o_full(w_c1_full), .o_empty(w_c1_empty)
  );

  assign w_c0_lines     = {8'd0, w_c0_head[1:0]} + 10'd1;
  assign w_rd_need      = {2'b00, r_rd_out} + w_c0_lines;
  assign w_c0_credit_ok = (w_rd_need <= 10'(MAX_RD_LINES));
  assign w_c0_issue     = !w_c0_empty && !c0_alm_full && w_c0_credit_ok;
  assign w_c1_issue     = !w_c1_empty && (!w_c1_head[0] || !c1_alm_full);

  // Issue and response in the same cycle net out before the clamp is applied.
  assign w_rd_sum  = {2'b00, r_rd_out} + (w_c0_issue ? w_c0_lines : 10'd0);
  assign w_rd_uf   = rd_rsp_valid && (w_rd_sum == 10'd0);
  assign w_rd_next = w_rd_uf ? 10'd0 : (w_rd_sum - {9'd0, rd_rsp_valid});
  assign w_wr_sum  = {2'b00, r_wr_out} + {9'd0, w_c1_issue};
  assign w_wr_sub  = wr_rsp_valid ? ({8'd0, wr_rsp_lines} + 10'd1) : 10'd0;
  assign w_wr_uf   = (w_wr_sum < w_wr_sub);
  assign w_wr_next = w_wr_uf ? 10'd0 : (w_wr_sum - w_wr_sub);

  assign w_idle = w_c0_empty && w_c1_empty && !r_out_c0_vld && !r_out_c1_vld &&
                  (r_rd_out == 8'd0) && (r_wr_out == 8'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_RUN;
      r_c1_started  <= 1'b0;
      r_out_c0_vld  <= 1'b0;
      r_out_c0_hdr  <= '0;
      r_out_c1_vld  <= 1'b0;
      r_out_c1_hdr  <= '0;
      r_out_c1_data <= '0;
      r_rd_out      <= 8'd0;
      r_wr_out      <= 8'd0;
      r_err         <= 1'b0;
    end else begin
      case (r_state)
        S_RUN:   if (drain_req) r_state <= S_DRAIN;
        S_DRAIN: if (w_idle) r_state <= S_DONE;
        S_DONE:  if (!drain_req) r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase
      r_c1_started <= r_c1_started | w_c1_push;
      r_out_c0_vld <= w_c0_issue;
      r_out_c1_vld <= w_c1_issue;
      if (w_c0_issue) r_out_c0_hdr <= w_c0_head[C0_W-1:2];
      if (w_c1_issue) begin
        r_out_c1_hdr  <= w_c1_head[C1_W-1:DATA_W+1];
        r_out_c1_data <= w_c1_head[DATA_W:1];
      end
      r_rd_out <= w_rd_next[7:0];
      r_wr_out <= w_wr_next[7:0];
      r_err    <= r_err | w_rd_uf | w_wr_uf;
    end
  end

  assign out_c0_valid   = r_out_c0_vld;
  assign out_c0_hdr     = r_out_c0_hdr;
  assign out_c1_valid   = r_out_c1_vld;
  assign out_c1_hdr     = r_out_c1_hdr;
  assign out_c1_data    = r_out_c1_data;
  assign rd_outstanding = r_rd_out;
  assign wr_outstanding = r_wr_out;
  assign err_underflow  = r_err;
  assign drain_done     = (r_state == S_DONE);

`ifdef REQ_THROTTLE_STATS_EN
  logic        w_af_stall, w_cr_stall;
  logic [31:0] r_stall_af, r_stall_cr;

  assign w_af_stall = (!w_c0_empty && c0_alm_full && w_c0_credit_ok) ||
                      (!w_c1_empty && w_c1_head[0] && c1_alm_full);
  assign w_cr_stall = !w_c0_empty && !w_c0_credit_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_af <= 32'd0;
      r_stall_cr <= 32'd0;
    end else begin
      if (w_af_stall && (r_stall_af != 32'hFFFF_FFFF)) r_stall_af <= r_stall_af + 32'd1;
      if (w_cr_stall && (r_stall_cr != 32'hFFFF_FFFF)) r_stall_cr <= r_stall_cr + 32'd1;
    end
  end

  assign stall_af_cnt = r_stall_af;
  assign stall_cr_cnt = r_stall_cr;
`else
  assign stall_af_cnt = 32'd0;
  assign stall_cr_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_req_throttle.sv
// Randomized + directed bench for req_throttle against a queue-based behavioural model.
`timescale 1ns/1ps

module tb_req_throttle;
  localparam int C0W   = 74;
  localparam int C1W   = 80;
  localparam int DW    = 512;
  localparam int DEPTH = 4;
  localparam int MAXRD = 64;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           in_c0_valid, in_c0_ready, in_c1_valid, in_c1_sop, in_c1_ready;
  logic [C0W-1:0] in_c0_hdr, out_c0_hdr;
  logic [1:0]     in_c0_len, wr_rsp_lines;
  logic [C1W-1:0] in_c1_hdr, out_c1_hdr;
  logic [DW-1:0]  in_c1_data, out_c1_data;
  logic           out_c0_valid, out_c1_valid, c0_alm_full, c1_alm_full;
  logic           rd_rsp_valid, wr_rsp_valid, drain_req, drain_done, err_underflow;
  logic [7:0]     rd_outstanding, wr_outstanding;
  logic [31:0]    stall_af_cnt, stall_cr_cnt;

  always #5 clk = ~clk;

  req_throttle dut (
    .clk(clk), .reset_n(reset_n),
    .in_c0_valid(in_c0_valid), .in_c0_hdr(in_c0_hdr), .in_c0_len(in_c0_len), .in_c0_ready(in_c0_ready),
    .in_c1_valid(in_c1_valid), .in_c1_hdr(in_c1_hdr), .in_c1_data(in_c1_data), .in_c1_sop(in_c1_sop),
    .in_c1_ready(in_c1_ready),
    .out_c0_valid(out_c0_valid), .out_c0_hdr(out_c0_hdr),
    .out_c1_valid(out_c1_valid), .out_c1_hdr(out_c1_hdr), .out_c1_data(out_c1_data),
    .c0_alm_full(c0_alm_full), .c1_alm_full(c1_alm_full),
    .rd_rsp_valid(rd_rsp_valid), .wr_rsp_valid(wr_rsp_valid), .wr_rsp_lines(wr_rsp_lines),
    .drain_req(drain_req), .drain_done(drain_done),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
    .err_underflow(err_underflow), .stall_af_cnt(stall_af_cnt), .stall_cr_cnt(stall_cr_cnt)
  );

  typedef struct { logic [C0W-1:0] hdr; int lines; } rd_req_t;
  typedef struct { logic [C1W-1:0] hdr; logic [DW-1:0] data; bit sop; } wr_beat_t;

  rd_req_t        q0[$];
  wr_beat_t       q1[$];
  int             m_rd, m_wr, m_mode;  // mode: 0 run, 1 drain, 2 done
  bit             m_err, m_started, m_o0_vld, m_o1_vld;
  logic [C0W-1:0] m_o0_hdr;
  logic [C1W-1:0] m_o1_hdr;
  logic [DW-1:0]  m_o1_data;
  longint         m_saf, m_scr;
  int             checks, errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_wide();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit m_rdy0();
    return (q0.size() < DEPTH) && (m_mode == 0);
  endfunction

  function automatic bit m_rdy1();
    return (q1.size() < DEPTH) && ((m_mode == 0) || ((m_mode == 1) && m_started && !in_c1_sop));
  endfunction

  task automatic model_reset();
    q0.delete(); q1.delete();
    m_rd = 0; m_wr = 0; m_mode = 0; m_err = 0; m_started = 0;
    m_o0_vld = 0; m_o1_vld = 0; m_o0_hdr = '0; m_o1_hdr = '0; m_o1_data = '0;
    m_saf = 0; m_scr = 0;
  endtask

  // Advance the model by one clock edge from the inputs currently applied.
  task automatic model_step();
    bit acc0, acc1, idle, has0, credit, iss0, iss1, af, cr;
    int add, sub;
    acc0 = in_c0_valid && m_rdy0();
    acc1 = in_c1_valid && m_rdy1();
    idle = (q0.size() == 0) && (q1.size() == 0) && !m_o0_vld && !m_o1_vld && (m_rd == 0) && (m_wr == 0);
    has0 = (q0.size() > 0);
    credit = 0;
    if (has0) credit = (m_rd + q0[0].lines) <= MAXRD;
    iss0 = has0 && !c0_alm_full && credit;
    iss1 = 0; af = has0 && c0_alm_full && credit;
    if (q1.size() > 0) begin
      iss1 = !q1[0].sop || !c1_alm_full;
      af   = af || (q1[0].sop && c1_alm_full);
    end
    cr = has0 && !credit;
    add = 0;
    m_o0_vld = iss0;
    if (iss0) begin m_o0_hdr = q0[0].hdr; add = q0[0].lines; q0.delete(0); end
    m_o1_vld = iss1;
    if (iss1) begin m_o1_hdr = q1[0].hdr; m_o1_data = q1[0].data; q1.delete(0); end
    m_rd = m_rd + add - (rd_rsp_valid ? 1 : 0);
    if (m_rd < 0) begin m_rd = 0; m_err = 1; end
    sub = wr_rsp_valid ? int'(wr_rsp_lines) + 1 : 0;
    m_wr = m_wr + (iss1 ? 1 : 0) - sub;
    if (m_wr < 0) begin m_wr = 0; m_err = 1; end
    case (m_mode)
      0: if (drain_req) m_mode = 1;
      1: if (idle) m_mode = 2;
      default: if (!drain_req) m_mode = 0;
    endcase
    if (acc0) q0.push_back('{hdr: in_c0_hdr, lines: int'(in_c0_len) + 1});
    if (acc1) q1.push_back('{hdr: in_c1_hdr, data: in_c1_data, sop: in_c1_sop || !m_started});
    if (acc1) m_started = 1;
`ifdef REQ_THROTTLE_STATS_EN
    if (af && m_saf < 64'hFFFF_FFFF) m_saf++;
    if (cr && m_scr < 64'hFFFF_FFFF) m_scr++;
`endif
  endtask

  task automatic check_outputs();
    chk("out_c0_valid", 64'(out_c0_valid), 64'(m_o0_vld));
    if (m_o0_vld) chkw("out_c0_hdr", DW'(out_c0_hdr), DW'(m_o0_hdr));
    chk("out_c1_valid", 64'(out_c1_valid), 64'(m_o1_vld));
    if (m_o1_vld) begin
      chkw("out_c1_hdr", DW'(out_c1_hdr), DW'(m_o1_hdr));
      chkw("out_c1_data", out_c1_data, m_o1_data);
    end
    chk("rd_outstanding", 64'(rd_outstanding), 64'(m_rd));
    chk("wr_outstanding", 64'(wr_outstanding), 64'(m_wr));
    chk("err_underflow", 64'(err_underflow), 64'(m_err));
    chk("drain_done", 64'(drain_done), 64'(m_mode == 2));
    chk("stall_af_cnt", 64'(stall_af_cnt), 64'(m_saf));
    chk("stall_cr_cnt", 64'(stall_cr_cnt), 64'(m_scr));
  endtask

  // Called at a negedge with inputs applied; returns at the next negedge.
  task automatic cycle();
    #1;
    chk("in_c0_ready", 64'(in_c0_ready), 64'(m_rdy0()));
    chk("in_c1_ready", 64'(in_c1_ready), 64'(m_rdy1()));
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_in();
    in_c0_valid = 0; in_c1_valid = 0; in_c1_sop = 0;
    rd_rsp_valid = 0; wr_rsp_valid = 0; wr_rsp_lines = 0;
  endtask

  task automatic rand_payload();
    logic [DW-1:0] t;
    t = rnd_wide(); in_c0_hdr = t[C0W-1:0];
    t = rnd_wide(); in_c1_hdr = t[C1W-1:0];
    in_c1_data = rnd_wide();
  endtask

  task automatic settle();
    idle_in(); c0_alm_full = 0; c1_alm_full = 0;
    for (int k = 0; k < 300; k++) begin
      if (q0.size() == 0 && q1.size() == 0 && !m_o0_vld && !m_o1_vld && m_rd == 0 && m_wr == 0) break;
      rd_rsp_valid = (m_rd > 0);
      wr_rsp_valid = (m_wr > 0);
      wr_rsp_lines = 2'(m_wr > 4 ? 3 : (m_wr > 0 ? m_wr - 1 : 0));
      cycle();
    end
    idle_in();
    chk("settle_rd", 64'(rd_outstanding), 64'd0);
    chk("settle_wr", 64'(wr_outstanding), 64'd0);
  endtask

  task automatic rand_phase(input int n, input bit use_drain);
    for (int i = 0; i < n; i++) begin
      rand_payload();
      if (use_drain && (i % 50 == 0)) drain_req = 1'($urandom_range(0, 1));
      in_c0_valid = 1'($urandom_range(0, 1));
      in_c0_len   = 2'($urandom_range(0, 3));
      in_c1_valid = 1'($urandom_range(0, 1));
      in_c1_sop   = ($urandom_range(0, 3) == 0);
      c0_alm_full = ($urandom_range(0, 3) == 0);
      c1_alm_full = ($urandom_range(0, 3) == 0);
      rd_rsp_valid = (m_rd > 0) && ($urandom_range(0, 1) == 1);
      wr_rsp_valid = (m_wr > 0) && (($urandom_range(0, 1) == 1) || m_wr > 8);
      wr_rsp_lines = 2'($urandom_range(0, (m_wr > 4) ? 3 : ((m_wr > 0) ? m_wr - 1 : 0)));
      if ($urandom_range(0, 63) == 0) begin
        rd_rsp_valid = 1; wr_rsp_valid = 1; wr_rsp_lines = 2'($urandom_range(0, 3));
      end
      cycle();
    end
    idle_in(); drain_req = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] vhist;
    int cnt;
    checks = 0; errors = 0;
    reset_n = 0; idle_in(); drain_req = 0; c0_alm_full = 0; c1_alm_full = 0;
    in_c0_len = 0; rand_payload();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_c0_ready", 64'(in_c0_ready), 64'd1);
    chk("rst_c1_ready", 64'(in_c1_ready), 64'd1);
    chk("rst_out_c0_valid", 64'(out_c0_valid), 64'd0);
    chk("rst_out_c1_valid", 64'(out_c1_valid), 64'd0);
    chk("rst_out_c0_hdr", 64'(out_c0_hdr[63:0]), 64'd0);
    chk("rst_rd_out", 64'(rd_outstanding), 64'd0);
    chk("rst_wr_out", 64'(wr_outstanding), 64'd0);
    chk("rst_err", 64'(err_underflow), 64'd0);
    chk("rst_drain_done", 64'(drain_done), 64'd0);
    chk("rst_stall_af", 64'(stall_af_cnt), 64'd0);
    reset_n = 1;

    // 8 back-to-back single-line reads: out_valid after edges 1..8
    for (int j = 0; j < 10; j++) begin
      rand_payload();
      in_c0_valid = (j < 8); in_c0_len = 0;
      cycle();
      vhist[j] = out_c0_valid;
    end
    chk("stream_pulses", 64'(vhist), 64'b01_1111_1110);
    chk("stream_rd_out", 64'(rd_outstanding), 64'd8);
    idle_in(); rd_rsp_valid = 1;
    repeat (8) cycle();
    idle_in();

    // credit hold at 62 with a 4-line head
    for (int i = 0; i < 17; i++) begin
      rand_payload();
      in_c0_valid = 1; in_c0_len = (i == 15) ? 2'd1 : 2'd3;
      cycle();
    end
    idle_in();
    repeat (3) cycle();
    chk("credit_rd62", 64'(rd_outstanding), 64'd62);
    chk("credit_held", 64'(out_c0_valid), 64'd0);
    rd_rsp_valid = 1;
    repeat (2) cycle();
    rd_rsp_valid = 0;
    cycle();
    chk("credit_issue", 64'(out_c0_valid), 64'd1);
    chk("credit_rd64", 64'(rd_outstanding), 64'd64);
    rd_rsp_valid = 1;
    repeat (64) cycle();
    idle_in();

    // alm_full after sop: non-sop beats still flow, next sop waits
    rand_payload(); in_c1_valid = 1; in_c1_sop = 1; cycle();
    rand_payload(); in_c1_sop = 0; cycle();
    c1_alm_full = 1; cnt = 0;
    for (int k = 0; k < 8; k++) begin
      rand_payload();
      in_c1_valid = (k < 3); in_c1_sop = (k == 2);
      cycle();
      cnt += int'(out_c1_valid);
    end
    chk("af_beats_issued", 64'(cnt), 64'd3);
    c1_alm_full = 0; idle_in();
    cycle();
    chk("af_sop_released", 64'(out_c1_valid), 64'd1);
    wr_rsp_valid = 1; wr_rsp_lines = 3; cycle();
    wr_rsp_lines = 0; cycle();
    chk("wr_cleared", 64'(wr_outstanding), 64'd0);
    chk("err_before_uf", 64'(err_underflow), 64'd0);

    // write underflow clamps and sets sticky error
    wr_rsp_lines = 1; cycle();
    idle_in();
    chk("uf_wr_clamped", 64'(wr_outstanding), 64'd0);
    chk("uf_err_set", 64'(err_underflow), 64'd1);
    cycle();

    rand_phase(400, 0);
    settle();
    chk("err_sticky", 64'(err_underflow), 64'd1);

    // drain mid 4-beat write with 2 read lines outstanding
    rand_payload(); in_c0_valid = 1; in_c0_len = 1; cycle();
    idle_in(); rand_payload(); in_c1_valid = 1; in_c1_sop = 1; cycle();
    rand_payload(); in_c1_sop = 0; drain_req = 1; cycle();
    for (int k = 0; k < 2; k++) begin
      rand_payload(); in_c1_valid = 1; in_c1_sop = 0;
      #1;
      chk("drain_c1_rdy_mid", 64'(in_c1_ready), 64'd1);
      chk("drain_c0_rdy", 64'(in_c0_ready), 64'd0);
      cycle();
    end
    rand_payload(); in_c1_valid = 1; in_c1_sop = 1;
    #1;
    chk("drain_c1_rdy_sop", 64'(in_c1_ready), 64'd0);
    cycle();
    idle_in();
    repeat (3) cycle();
    chk("drain_wr4", 64'(wr_outstanding), 64'd4);
    chk("drain_not_done", 64'(drain_done), 64'd0);
    rd_rsp_valid = 1; repeat (2) cycle();
    idle_in(); wr_rsp_valid = 1; wr_rsp_lines = 3; cycle();
    idle_in();
    chk("drain_pending", 64'(drain_done), 64'd0);
    cycle();
    chk("drain_done_set", 64'(drain_done), 64'd1);
    drain_req = 0; cycle();
    chk("drain_to_run", 64'(drain_done), 64'd0);
    #1;
    chk("run_c0_rdy", 64'(in_c0_ready), 64'd1);
    cycle();

    rand_phase(500, 1);

    // asynchronous reset mid-stream, no clock edge in between
    rand_phase(20, 0);
    rand_payload(); in_c0_valid = 1; in_c1_valid = 1; rd_rsp_valid = 1;
    #2; reset_n = 0; #1;
    chk("areset_out_c0_valid", 64'(out_c0_valid), 64'd0);
    chk("areset_out_c1_valid", 64'(out_c1_valid), 64'd0);
    chk("areset_rd_out", 64'(rd_outstanding), 64'd0);
    chk("areset_wr_out", 64'(wr_outstanding), 64'd0);
    chk("areset_err", 64'(err_underflow), 64'd0);
    chk("areset_c0_ready", 64'(in_c0_ready), 64'd1);
    chk("areset_c1_ready", 64'(in_c1_ready), 64'd1);
    model_reset();
    idle_in(); c0_alm_full = 0; c1_alm_full = 0; drain_req = 0;
    @(negedge clk); @(negedge clk);
    reset_n = 1;

    // 10 alm_full stall cycles on a c0 head
    rand_payload(); in_c0_valid = 1; in_c0_len = 0; c0_alm_full = 1; cycle();
    idle_in();
    repeat (10) cycle();
`ifdef REQ_THROTTLE_STATS_EN
    chk("stall_af_10", 64'(stall_af_cnt), 64'd10);
`else
    chk("stall_af_tied", 64'(stall_af_cnt), 64'd0);
`endif
    c0_alm_full = 0; cycle();

    // first c1 beat after reset is a sop even without in_c1_sop
    rand_payload(); in_c1_valid = 1; in_c1_sop = 0; c1_alm_full = 1; cycle();
    idle_in(); cnt = 0;
    for (int k = 0; k < 3; k++) begin cycle(); cnt += int'(out_c1_valid); end
    chk("post_rst_sop_held", 64'(cnt), 64'd0);
    c1_alm_full = 0; cycle();
    chk("post_rst_sop_issue", 64'(out_c1_valid), 64'd1);

    rand_phase(200, 1);
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
